demux_32bit_buf: RTL and testbench

Buffered 1-to-2 data distributor for the 32-bit datapath, the write-side counterpart of the 2:1 data select: one producer stream is steered by a per-word `select` bit into one of two independently drained consumer queues. Each destination has its own small FIFO and valid/ready handshake, so one stalled consumer never blocks words headed to the other. It sits between a shared result source and two downstream consumers, such as a write-back path and a side buffer.

---
 rtl/demux_32bit_buf.sv | 117 +++++++++++
 tb/tb_demux_32bit_buf.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_32bit_buf.sv
// rtl/demux_32bit_buf.sv - buffered 1-to-2 32-bit data distributor with per-output FIFOs
//
// Purpose: steers each producer word, by its select bit, into one of two
// independent FIFOs, each drained by its own valid/ready consumer. A stalled
// consumer only stalls producer words aimed at its own queue.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   data_in, select,    producer word, destination (0 -> out1, 1 -> out2),
//   in_valid, in_ready  producer handshake (in_ready = !full of selected FIFO)
//   data1_out,          head of FIFO 1 with consumer 1 handshake
//   out1_valid, out1_ready
//   data2_out,          head of FIFO 2 with consumer 2 handshake
//   out2_valid, out2_ready
//   busy                either FIFO holds a word
//
// Optional feature: define DEMUX_BYPASS_EN to compile in a zero-latency
// bypass that hands a word straight to an empty, ready output.

module demux_32bit_buf #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        select,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] data1_out,
  output logic        out1_valid,
  input  logic        out1_ready,
  output logic [31:0] data2_out,
  output logic        out2_valid,
  input  logic        out2_ready,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]  full;
  logic [1:0]  empty;
  logic [1:0]  rdy;
  logic [1:0]  valid;
  logic [1:0]  bypass;
  logic [31:0] head [2];

  assign rdy = {out2_ready, out1_ready};

  // Fullness only: a pop this cycle does not open space for a push this cycle,
  // which keeps outN_ready off the in_ready path.
  assign in_ready = !full[select];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          target;
    logic          push;
    logic          pop;

    assign target   = (select == 1'(g));
    assign empty[g] = (cnt_q == '0);
    assign full[g]  = (cnt_q == CW'(DEPTH));

`ifdef DEMUX_BYPASS_EN
    // Word goes straight through an empty FIFO whose consumer is ready now.
    assign bypass[g] = empty[g] && rdy[g] && in_valid && target;
`else
    assign bypass[g] = 1'b0;
`endif

    assign push     = in_valid && target && !full[g] && !bypass[g];
    assign pop      = !empty[g] && rdy[g];
    assign valid[g] = !empty[g] || bypass[g];
    assign head[g]  = bypass[g] ? data_in : mem_q[rptr_q];

    // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    // Storage is deliberately left out of reset; the count alone marks validity.
    always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= data_in;
    end
  end

  assign data1_out  = head[0];
  assign data2_out  = head[1];
  assign out1_valid = valid[0];
  assign out2_valid = valid[1];
  assign busy       = !empty[0] || !empty[1];

endmodule

// File: tb/tb_demux_32bit_buf.sv
// tb/tb_demux_32bit_buf.sv - directed self-checking bench for demux_32bit_buf

module tb_demux_32bit_buf;

`ifdef DEMUX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data1_out;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] data2_out;
  logic        out2_valid;
  logic        out2_ready;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] got [$];

  demux_32bit_buf #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .select     (select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data1_out  (data1_out),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .data2_out  (data2_out),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    total_cnt++; if (out1_valid !== 1'b0) $display("FAIL reset_out1_valid got %0b want 0", out1_valid); else pass_cnt++;
    total_cnt++; if (out2_valid !== 1'b0) $display("FAIL reset_out2_valid got %0b want 0", out2_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid;
    out1_ready = 1'b0;
    select = 1'b0; in_valid = 1'b1; data_in = 32'h1111_1111;
    cyc();
    data_in = 32'h2222_2222;
    cyc();
    in_valid = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_full got %0b want 1", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready_full got %0b want 0", in_ready); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++; if (out1_valid !== 1'b0) $display("FAIL mid_rst_out1_valid got %0b want 0", out1_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got %0b want 1", in_ready); else pass_cnt++;
    #1 rst = 1'b0;
    cyc();
    in_valid = 1'b1; data_in = 32'hAAAA_0001;
    cyc();
    in_valid = 1'b0;
    #1;
    total_cnt++; if (out1_valid !== 1'b1) $display("FAIL post_rst_valid got %0b want 1", out1_valid); else pass_cnt++;
    total_cnt++; if (data1_out !== 32'hAAAA_0001) $display("FAIL post_rst_data got %h want aaaa0001", data1_out); else pass_cnt++;
    out1_ready = 1'b1;
    cyc();
    out1_ready = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL post_rst_drain_busy got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_steering;
    logic        v [4];
    logic        s [4];
    logic [31:0] d [4];
    int n1, n2, c1, c2;
    logic [31:0] d1, d2;
    v = '{1'b1, 1'b1, 1'b0, 1'b0};
    s = '{1'b0, 1'b1, 1'b0, 1'b0};
    d = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0, 32'h0};
    n1 = 0; n2 = 0; c1 = -1; c2 = -1; d1 = '0; d2 = '0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = v[k]; select = s[k]; data_in = d[k];
      #1;
      if (out1_valid) begin n1++; c1 = k; d1 = data1_out; end
      if (out2_valid) begin n2++; c2 = k; d2 = data2_out; end
      cyc();
    end
    total_cnt++; if (n1 != 1) $display("FAIL steer_out1_cycles got %0d want 1", n1); else pass_cnt++;
    total_cnt++; if (d1 !== 32'hDEAD_BEEF) $display("FAIL steer_out1_data got %h want deadbeef", d1); else pass_cnt++;
    total_cnt++; if (c1 != (BYP ? 0 : 1)) $display("FAIL steer_out1_when got %0d want %0d", c1, BYP ? 0 : 1); else pass_cnt++;
    total_cnt++; if (n2 != 1) $display("FAIL steer_out2_cycles got %0d want 1", n2); else pass_cnt++;
    total_cnt++; if (d2 !== 32'hCAFE_F00D) $display("FAIL steer_out2_data got %h want cafef00d", d2); else pass_cnt++;
    total_cnt++; if (c2 != (BYP ? 1 : 2)) $display("FAIL steer_out2_when got %0d want %0d", c2, BYP ? 1 : 2); else pass_cnt++;
    out1_ready = 1'b0; out2_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    out1_ready = 1'b0; out2_ready = 1'b0;
    select = 1'b0; in_valid = 1'b1; data_in = 32'd1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_empty got %0b want 1", in_ready); else pass_cnt++;
    cyc();
    data_in = 32'd2;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one got %0b want 1", in_ready); else pass_cnt++;
    cyc();
    data_in = 32'd3;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full got %0b want 0", in_ready); else pass_cnt++;
    cyc();
    total_cnt++; if (in_ready !== 1'b0 || data1_out !== 32'd1) $display("FAIL bp_hold got ready=%0b head=%h want ready=0 head=1", in_ready, data1_out); else pass_cnt++;
    select = 1'b1; data_in = 32'h55;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_sel2 got %0b want 1", in_ready); else pass_cnt++;
    cyc();
    select = 1'b0; data_in = 32'd3;
    #1;
    total_cnt++; if (out2_valid !== 1'b1 || data2_out !== 32'h55) $display("FAIL bp_fifo2 got v=%0b d=%h want v=1 d=55", out2_valid, data2_out); else pass_cnt++;
    out1_ready = 1'b1;
    cyc();
    total_cnt++; if (data1_out !== 32'd2 || in_ready !== 1'b1) $display("FAIL bp_drain1 got head=%h ready=%0b want head=2 ready=1", data1_out, in_ready); else pass_cnt++;
    cyc();
    in_valid = 1'b0;
    #1;
    total_cnt++; if (out1_valid !== 1'b1 || data1_out !== 32'd3) $display("FAIL bp_drain2 got v=%0b head=%h want v=1 head=3", out1_valid, data1_out); else pass_cnt++;
    cyc();
    total_cnt++; if (out1_valid !== 1'b0) $display("FAIL bp_drain_empty got %0b want 0", out1_valid); else pass_cnt++;
    out1_ready = 1'b0; out2_ready = 1'b1;
    cyc();
    out2_ready = 1'b0;
    total_cnt++; if (out2_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_end got v2=%0b busy=%0b want 0 0", out2_valid, busy); else pass_cnt++;
  endtask

  task automatic test_streaming;
    int nready;
    nready = 0;
    got.delete();
    out1_ready = 1'b1; select = 1'b0;
    for (int i = 0; i < 22; i++) begin
      in_valid = (i < 20);
      data_in  = 32'(i);
      #1;
      if (i < 20 && in_ready !== 1'b1) nready++;
      if (out1_valid) got.push_back(data1_out);
      cyc();
    end
    in_valid = 1'b0;
    total_cnt++; if (nready != 0) $display("FAIL stream_in_ready_drops got %0d want 0", nready); else pass_cnt++;
    total_cnt++; if (got.size() != 20) $display("FAIL stream_count got %0d want 20", got.size()); else pass_cnt++;
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      total_cnt++; if (got[i] !== 32'(i)) $display("FAIL stream_word%0d got %h want %h", i, got[i], 32'(i)); else pass_cnt++;
    end
    total_cnt++; if (busy !== 1'b0) $display("FAIL stream_end_busy got %0b want 0", busy); else pass_cnt++;
    out1_ready = 1'b0;
  endtask

  task automatic test_independence;
    got.delete();
    out1_ready = 1'b0; out2_ready = 1'b0;
    select = 1'b1; in_valid = 1'b1; data_in = 32'hB0;
    cyc();
    data_in = 32'hB1;
    cyc();
    out1_ready = 1'b1; select = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      data_in  = 32'hC0 + 32'(i);
      #1;
      if (out1_valid) got.push_back(data1_out);
      cyc();
    end
    in_valid = 1'b0; out1_ready = 1'b0;
    total_cnt++; if (got.size() != 8) $display("FAIL indep_count got %0d want 8", got.size()); else pass_cnt++;
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      total_cnt++; if (got[i] !== 32'hC0 + 32'(i)) $display("FAIL indep_word%0d got %h want %h", i, got[i], 32'hC0 + 32'(i)); else pass_cnt++;
    end
    select = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b0 || data2_out !== 32'hB0) $display("FAIL indep_fifo2 got ready=%0b head=%h want ready=0 head=b0", in_ready, data2_out); else pass_cnt++;
    out2_ready = 1'b1;
    cyc();
    total_cnt++; if (out2_valid !== 1'b1 || data2_out !== 32'hB1) $display("FAIL indep_fifo2_second got v=%0b head=%h want v=1 head=b1", out2_valid, data2_out); else pass_cnt++;
    cyc();
    out2_ready = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL indep_end_busy got %0b want 0", busy); else pass_cnt++;
  endtask

`ifdef DEMUX_BYPASS_EN
  task automatic test_bypass;
    out1_ready = 1'b1; select = 1'b0; in_valid = 1'b1; data_in = 32'h1234_5678;
    #1;
    total_cnt++; if (out1_valid !== 1'b1 || data1_out !== 32'h1234_5678) $display("FAIL bypass_same_cycle got v=%0b d=%h want v=1 d=12345678", out1_valid, data1_out); else pass_cnt++;
    cyc();
    in_valid = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0 || out1_valid !== 1'b0) $display("FAIL bypass_not_queued got busy=%0b v=%0b want 0 0", busy, out1_valid); else pass_cnt++;
    out1_ready = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; data_in = '0; select = 1'b0; in_valid = 1'b0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    test_reset();
    test_reset_mid();
    test_steering();
    test_backpressure();
    test_streaming();
    test_independence();
`ifdef DEMUX_BYPASS_EN
    test_bypass();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
